jtcontra_gfxrom_slots: RTL and testbench

//  SDRAM-side responder for the two gfx chip ROM request channels (gfx1/gfx2 addr, romcs -> data, ok).

---
 rtl/jtcontra_gfxrom_pkg.sv | 15 +
 rtl/jtcontra_gfxrom_slots_if.sv | 35 +++
 rtl/jtcontra_gfxrom_client.sv | 36 +++
 rtl/jtcontra_gfxrom_slots.sv | 138 +++++++++++++
 tb/tb_jtcontra_gfxrom_slots.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/jtcontra_gfxrom_pkg.sv
// Shared widths and FSM state encoding for the gfx ROM slot responder.
package jtcontra_gfxrom_pkg;

    localparam int unsigned CLIENT_AW = 18;
    localparam int unsigned SDRAM_AW  = 22;
    localparam int unsigned DW        = 16;
    localparam int unsigned TOUT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/jtcontra_gfxrom_slots_if.sv
// Bundle of the two gfx client channels and the SDRAM read port.
interface jtcontra_gfxrom_slots_if;
    import jtcontra_gfxrom_pkg::*;

    logic [CLIENT_AW-1:0] gfx1_addr;
    logic                 gfx1_cs;
    logic [DW-1:0]        gfx1_data;
    logic                 gfx1_ok;
    logic [CLIENT_AW-1:0] gfx2_addr;
    logic                 gfx2_cs;
    logic [DW-1:0]        gfx2_data;
    logic                 gfx2_ok;
    logic [SDRAM_AW-1:0]  sdram_addr;
    logic                 sdram_req;
    logic                 sdram_ack;
    logic                 data_rdy;
    logic [DW-1:0]        data_read;

    // Responder side: serves gfx clients, issues SDRAM reads
    modport slave (
        input  gfx1_addr, gfx1_cs, gfx2_addr, gfx2_cs,
        input  sdram_ack, data_rdy, data_read,
        output gfx1_data, gfx1_ok, gfx2_data, gfx2_ok,
        output sdram_addr, sdram_req
    );

    // Environment side: gfx chips plus SDRAM controller
    modport master (
        output gfx1_addr, gfx1_cs, gfx2_addr, gfx2_cs,
        output sdram_ack, data_rdy, data_read,
        input  gfx1_data, gfx1_ok, gfx2_data, gfx2_ok,
        input  sdram_addr, sdram_req
    );

endinterface

// File: rtl/jtcontra_gfxrom_client.sv
// One-word cache for a single gfx client: tag/valid/data, hit compare, fill port.
module jtcontra_gfxrom_client
    import jtcontra_gfxrom_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CLIENT_AW-1:0] addr,
    input  logic                 cs,
    input  logic                 fill,
    input  logic [CLIENT_AW-1:0] fill_tag,
    input  logic [DW-1:0]        fill_data,
    output logic [DW-1:0]        data,
    output logic                 ok,
    output logic                 miss
);

    logic [CLIENT_AW-1:0] tag;
    logic                 valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag   <= '0;
            valid <= 1'b0;
            data  <= '0;
        end else if (fill) begin
            tag   <= fill_tag;
            valid <= 1'b1;
            data  <= fill_data;
        end
    end

    // Hit is combinational so a cached word is served regardless of SDRAM activity
    assign ok   = cs & valid & (addr == tag);
    assign miss = cs & ~ok;

endmodule

// File: rtl/jtcontra_gfxrom_slots.sv
// SDRAM-side responder for the gfx1/gfx2 ROM channels with a one-word cache each.
// Optional WAIT-state watchdog enabled by defining JTCONTRA_GFXROM_TOUT_EN.
module jtcontra_gfxrom_slots
    import jtcontra_gfxrom_pkg::*;
#(
    parameter logic [SDRAM_AW-1:0] GFX1_OFFSET = 22'h0,
    parameter logic [SDRAM_AW-1:0] GFX2_OFFSET = 22'h40000
`ifdef JTCONTRA_GFXROM_TOUT_EN
    ,
    parameter int unsigned TOUT = 255
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    jtcontra_gfxrom_slots_if.slave  bus
);

    state_t               state, state_nx;
    logic                 sel, sel_nx;
    logic                 rr, rr_nx;
    logic [CLIENT_AW-1:0] lock_addr, lock_nx;
    logic                 req, req_nx;
    logic [SDRAM_AW-1:0]  addr, addr_nx;
    logic                 miss1, miss2, pick;
    logic                 fill1, fill2;
`ifdef JTCONTRA_GFXROM_TOUT_EN
    logic [TOUT_W-1:0]    cnt, cnt_nx;
`endif

    jtcontra_gfxrom_client u_gfx1 (
        .clk       (clk),
        .rst       (rst),
        .addr      (bus.gfx1_addr),
        .cs        (bus.gfx1_cs),
        .fill      (fill1),
        .fill_tag  (lock_addr),
        .fill_data (bus.data_read),
        .data      (bus.gfx1_data),
        .ok        (bus.gfx1_ok),
        .miss      (miss1)
    );

    jtcontra_gfxrom_client u_gfx2 (
        .clk       (clk),
        .rst       (rst),
        .addr      (bus.gfx2_addr),
        .cs        (bus.gfx2_cs),
        .fill      (fill2),
        .fill_tag  (lock_addr),
        .fill_data (bus.data_read),
        .data      (bus.gfx2_data),
        .ok        (bus.gfx2_ok),
        .miss      (miss2)
    );

    // rr names the client that wins a simultaneous miss (the one not served last)
    assign pick = (miss1 & miss2) ? rr : miss2;

    assign bus.sdram_req  = req;
    assign bus.sdram_addr = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 1'b0;
            rr        <= 1'b0;
            lock_addr <= '0;
            req       <= 1'b0;
            addr      <= '0;
`ifdef JTCONTRA_GFXROM_TOUT_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            rr        <= rr_nx;
            lock_addr <= lock_nx;
            req       <= req_nx;
            addr      <= addr_nx;
`ifdef JTCONTRA_GFXROM_TOUT_EN
            cnt       <= cnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        rr_nx    = rr;
        lock_nx  = lock_addr;
        req_nx   = req;
        addr_nx  = addr;
        fill1    = 1'b0;
        fill2    = 1'b0;
`ifdef JTCONTRA_GFXROM_TOUT_EN
        cnt_nx   = cnt;
`endif
        case (state)
            IDLE: begin
                if (miss1 | miss2) begin
                    sel_nx   = pick;
                    lock_nx  = pick ? bus.gfx2_addr : bus.gfx1_addr;
                    addr_nx  = (pick ? GFX2_OFFSET : GFX1_OFFSET) + SDRAM_AW'(lock_nx);
                    req_nx   = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                // ack wins over a coincident data_rdy
                if (bus.sdram_ack) begin
                    req_nx   = 1'b0;
                    state_nx = WAIT;
`ifdef JTCONTRA_GFXROM_TOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            WAIT: begin
                if (bus.data_rdy) begin
                    fill1    = ~sel;
                    fill2    = sel;
                    rr_nx    = ~sel;
                    state_nx = IDLE;
                end
`ifdef JTCONTRA_GFXROM_TOUT_EN
                else if (cnt == TOUT_W'(TOUT - 1)) begin
                    req_nx   = 1'b1;
                    state_nx = REQ;
                end else begin
                    cnt_nx   = cnt + TOUT_W'(1);
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jtcontra_gfxrom_slots.sv
// Directed self-checking bench for jtcontra_gfxrom_slots (optionally with JTCONTRA_GFXROM_TOUT_EN).
module tb_jtcontra_gfxrom_slots;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    jtcontra_gfxrom_slots_if bus ();

    jtcontra_gfxrom_slots #(
        .GFX1_OFFSET (22'h0),
        .GFX2_OFFSET (22'h40000)
`ifdef JTCONTRA_GFXROM_TOUT_EN
        ,
        .TOUT        (8)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle where sdram_req is high: ack, then return data
    task automatic serve(input logic [15:0] d);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = d;
        tick();
        bus.data_rdy  = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.gfx1_addr = '0;
        bus.gfx1_cs   = 1'b0;
        bus.gfx2_addr = '0;
        bus.gfx2_cs   = 1'b0;
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        bus.data_read = '0;
        do_reset();
        #1;
        chk("rst_req",   32'(bus.sdram_req),  32'd0);
        chk("rst_addr",  32'(bus.sdram_addr), 32'd0);
        chk("rst_d1",    32'(bus.gfx1_data),  32'd0);
        chk("rst_d2",    32'(bus.gfx2_data),  32'd0);

        // First gfx1 miss and fill
        tick();
        bus.gfx1_addr = 18'h00010;
        bus.gfx1_cs   = 1'b1;
        #1;
        chk("miss_ok0",  32'(bus.gfx1_ok),    32'd0);
        tick();
        chk("c1_req",    32'(bus.sdram_req),  32'd1);
        chk("c1_addr",   32'(bus.sdram_addr), 32'h00010);
        serve(16'hBEEF);
        chk("fill_req0", 32'(bus.sdram_req),  32'd0);
        chk("fill_ok",   32'(bus.gfx1_ok),    32'd1);
        chk("fill_data", 32'(bus.gfx1_data),  32'hBEEF);

        // Repeated address hits without new fetch
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hit_req",   32'(bus.sdram_req), 32'd0);
            chk("hit_ok",    32'(bus.gfx1_ok),   32'd1);
        end

        // New address: ok drops at once, new fetch
        bus.gfx1_addr = 18'h00011;
        #1;
        chk("chg_ok0",   32'(bus.gfx1_ok),    32'd0);
        tick();
        chk("chg_req",   32'(bus.sdram_req),  32'd1);
        chk("chg_addr",  32'(bus.sdram_addr), 32'h00011);
        serve(16'h1234);
        chk("chg_ok",    32'(bus.gfx1_ok),    32'd1);
        chk("chg_data",  32'(bus.gfx1_data),  32'h1234);

        // Both miss in the same cycle after reset: gfx1 first, then gfx2
        bus.gfx1_cs = 1'b0;
        do_reset();
        bus.gfx1_addr = 18'h00020;
        bus.gfx2_addr = 18'h00030;
        bus.gfx1_cs   = 1'b1;
        bus.gfx2_cs   = 1'b1;
        #1;
        chk("rst2_ok1",  32'(bus.gfx1_ok),    32'd0);
        tick();
        chk("arb_req",   32'(bus.sdram_req),  32'd1);
        chk("arb_addr1", 32'(bus.sdram_addr), 32'h00020);
        serve(16'hAAAA);
        chk("arb_ok1",   32'(bus.gfx1_ok),    32'd1);
        chk("arb_d1",    32'(bus.gfx1_data),  32'hAAAA);
        chk("arb_ok2_0", 32'(bus.gfx2_ok),    32'd0);
        tick();
        chk("arb_req2",  32'(bus.sdram_req),  32'd1);
        chk("arb_addr2", 32'(bus.sdram_addr), 32'h40030);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        chk("nostall",   32'(bus.gfx1_ok),    32'd1);
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h5555;
        tick();
        bus.data_rdy  = 1'b0;
        #1;
        chk("arb_ok2",   32'(bus.gfx2_ok),    32'd1);
        chk("arb_d2",    32'(bus.gfx2_data),  32'h5555);
        chk("arb_ok1_k", 32'(bus.gfx1_ok),    32'd1);

        // gfx2 moves during WAIT; ack+data_rdy together counts as ack only
        bus.gfx1_cs   = 1'b0;
        bus.gfx2_addr = 18'h00031;
        tick();
        chk("mv_addr",   32'(bus.sdram_addr), 32'h40031);
        bus.sdram_ack = 1'b1;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'hDEAD;
        tick();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        #1;
        chk("ackrdy_req", 32'(bus.sdram_req), 32'd0);
        chk("ackrdy_d",   32'(bus.gfx2_data), 32'h5555);
        bus.gfx2_addr = 18'h00032;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h7777;
        tick();
        bus.data_rdy  = 1'b0;
        #1;
        chk("mv_ok0",    32'(bus.gfx2_ok),    32'd0);
        chk("mv_d",      32'(bus.gfx2_data),  32'h7777);
        tick();
        chk("mv_req",    32'(bus.sdram_req),  32'd1);
        chk("mv_addr2",  32'(bus.sdram_addr), 32'h40032);
        serve(16'h8888);
        chk("mv_ok",     32'(bus.gfx2_ok),    32'd1);
        chk("mv_d2",     32'(bus.gfx2_data),  32'h8888);

        // Reset in WAIT, late data_rdy ignored
        bus.gfx2_addr = 18'h00040;
        tick();
        chk("rw_req",    32'(bus.sdram_req),  32'd1);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        rst           = 1'b1;
        bus.gfx2_cs   = 1'b0;
        tick();
        rst           = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h9999;
        tick();
        bus.data_rdy  = 1'b0;
        #1;
        chk("rw_req0",   32'(bus.sdram_req),  32'd0);
        chk("rw_d",      32'(bus.gfx2_data),  32'd0);
        bus.gfx2_cs = 1'b1;
        #1;
        chk("rw_ok0",    32'(bus.gfx2_ok),    32'd0);
        tick();
        chk("rw_idle",   32'(bus.sdram_req),  32'd1);
        chk("rw_addr",   32'(bus.sdram_addr), 32'h40040);
        serve(16'h4242);
        chk("rw_ok",     32'(bus.gfx2_ok),    32'd1);

`ifdef JTCONTRA_GFXROM_TOUT_EN
        // Watchdog: 8 WAIT cycles without data_rdy re-issue the request
        bus.gfx2_cs   = 1'b0;
        bus.gfx1_addr = 18'h00005;
        bus.gfx1_cs   = 1'b1;
        tick();
        chk("to_req",    32'(bus.sdram_req),  32'd1);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("to_wait",   32'(bus.sdram_req), 32'd0);
            tick();
        end
        chk("to_wait7",  32'(bus.sdram_req),  32'd0);
        tick();
        chk("to_rereq",  32'(bus.sdram_req),  32'd1);
        chk("to_addr",   32'(bus.sdram_addr), 32'h00005);
        serve(16'h0F0F);
        chk("to_ok",     32'(bus.gfx1_ok),    32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
